// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequencer: FSM state encoding, width helpers, default address width.
package lstm_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ACC   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int LSTM_AW_DEFAULT = 16;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Counter register width; a modulus of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/lstm_seq_ctrl_counter.sv
// mod_counter: wrap-around counter with enable, synchronous clear and terminal-count flag.
module mod_counter
    import lstm_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign o_last = (cnt_q == W'(MAX - 1));
    assign o_cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = o_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// LSTM core sequencer: MAC control, operand/state addressing and c/h write strobes over units and timesteps.
// Optional stall input enabled by defining LSTM_SEQ_CTRL_STALL_EN.
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int N_X    = 4,
    parameter int N_H    = 4,
    parameter int N_UNIT = 4,
    parameter int N_T    = 8,
    parameter int AW     = LSTM_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
`ifdef LSTM_SEQ_CTRL_STALL_EN
    input  logic          i_stall,
`endif
    output logic          o_acc_x,
    output logic          o_acc_h,
    output logic          o_x_en,
    output logic          o_h_en,
    output logic [AW-1:0] o_x_addr,
    output logic [AW-1:0] o_w_addr,
    output logic [AW-1:0] o_h_addr,
    output logic [AW-1:0] o_u_addr,
    output logic          o_h_bank,
    output logic [AW-1:0] o_c_addr,
    output logic          o_first,
    output logic          o_wr,
    output logic          o_busy,
    output logic          o_done
);

    localparam int N_IN = (N_X > N_H) ? N_X : N_H;
    localparam int KW   = cnt_w(N_IN);
    localparam int UW   = cnt_w(N_UNIT);
    localparam int SW   = cnt_w(N_T);

    generate
        if ((longint'(N_UNIT) * N_X > (longint'(1) << AW)) ||
            (longint'(N_UNIT) * N_H > (longint'(1) << AW)) ||
            (longint'(N_T) * N_X > (longint'(1) << AW))) begin : g_aw_check
            $error("lstm_seq_ctrl: AW too narrow for the address range");
        end
    endgenerate

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic          k_en;
    logic          unit_en;
    logic          step_en;
    logic          cnt_clr;
    logic [KW-1:0] k_cnt;
    logic [UW-1:0] unit_cnt;
    logic [SW-1:0] step_cnt;
    logic          k_last;
    logic          unit_last;
    logic          step_last;
    logic          stall_act;

    logic is_load, is_acc, is_wait, is_write, is_done, busy, first, mac_phase;

    assign is_load  = (state_q == ST_LOAD);
    assign is_acc   = (state_q == ST_ACC);
    assign is_wait  = (state_q == ST_WAIT);
    assign is_write = (state_q == ST_WRITE);
    assign is_done  = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);

`ifdef LSTM_SEQ_CTRL_STALL_EN
    // WRITE and DONE are not listed: a stall there is deferred until the next LOAD.
    assign stall_act = i_stall && (is_load || is_acc || is_wait);
`else
    assign stall_act = 1'b0;
`endif

    mod_counter #(.MAX(N_IN), .W(KW)) u_k (
        .clk(clk), .rst(rst), .en(k_en), .clr(cnt_clr), .o_cnt(k_cnt), .o_last(k_last)
    );

    mod_counter #(.MAX(N_UNIT), .W(UW)) u_unit (
        .clk(clk), .rst(rst), .en(unit_en), .clr(cnt_clr), .o_cnt(unit_cnt), .o_last(unit_last)
    );

    mod_counter #(.MAX(N_T), .W(SW)) u_step (
        .clk(clk), .rst(rst), .en(step_en), .clr(cnt_clr), .o_cnt(step_cnt), .o_last(step_last)
    );

    always_comb begin
        state_d = state_q;
        k_en    = 1'b0;
        unit_en = 1'b0;
        step_en = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (i_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!stall_act) begin
                    if (N_IN > 1) begin
                        k_en    = 1'b1;
                        state_d = ST_ACC;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_ACC: begin
                // k wraps back to 0 on its last term, ready for the next unit.
                if (!stall_act) begin
                    k_en = 1'b1;
                    if (k_last) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!stall_act) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!unit_last) begin
                    unit_en = 1'b1;
                    state_d = ST_LOAD;
                end else if (!step_last) begin
                    unit_en = 1'b1;
                    step_en = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign first     = busy && (step_cnt == '0);
    assign mac_phase = (is_load || is_acc) && !stall_act;

    assign o_acc_x  = is_acc || is_wait || is_write;
    assign o_acc_h  = is_acc || is_wait || is_write;
    assign o_x_en   = mac_phase && (int'(k_cnt) < N_X);
    assign o_h_en   = mac_phase && (int'(k_cnt) < N_H) && !first;
    assign o_x_addr = AW'(step_cnt) * AW'(N_X) + AW'(k_cnt);
    assign o_w_addr = AW'(unit_cnt) * AW'(N_X) + AW'(k_cnt);
    assign o_h_addr = AW'(k_cnt);
    assign o_u_addr = AW'(unit_cnt) * AW'(N_H) + AW'(k_cnt);
    assign o_h_bank = step_cnt[0];
    assign o_c_addr = AW'(unit_cnt);
    assign o_first  = first;
    assign o_wr     = is_write;
    assign o_busy   = busy;
    assign o_done   = is_done;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: two configurations driven with randomized timing and checked
// against a per-cycle expected-output schedule built from the sequencing rules.
module tb_lstm_seq_ctrl;

    typedef struct packed {
        logic        acc_x;
        logic        acc_h;
        logic        x_en;
        logic        h_en;
        logic [15:0] xa;
        logic [15:0] wa;
        logic [15:0] ha;
        logic [15:0] ua;
        logic        bank;
        logic [15:0] ca;
        logic        first;
        logic        wr;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct packed {
        logic       stallable;
        logic [1:0] mask;
        obs_t       o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, stall;
    logic sb_on;
    int   n_cmp, n_fail;

    logic a_acc_x, a_acc_h, a_x_en, a_h_en, a_bank, a_first, a_wr, a_busy, a_done;
    logic [15:0] a_xa, a_wa, a_ha, a_ua, a_ca;
    logic b_acc_x, b_acc_h, b_x_en, b_h_en, b_bank, b_first, b_wr, b_busy, b_done;
    logic [15:0] b_xa, b_wa, b_ha, b_ua, b_ca;

    obs_t obs [2];
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    lstm_seq_ctrl #(.N_X(4), .N_H(4), .N_UNIT(2), .N_T(2), .AW(16)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a),
`ifdef LSTM_SEQ_CTRL_STALL_EN
        .i_stall(stall),
`endif
        .o_acc_x(a_acc_x), .o_acc_h(a_acc_h), .o_x_en(a_x_en), .o_h_en(a_h_en),
        .o_x_addr(a_xa), .o_w_addr(a_wa), .o_h_addr(a_ha), .o_u_addr(a_ua),
        .o_h_bank(a_bank), .o_c_addr(a_ca), .o_first(a_first), .o_wr(a_wr),
        .o_busy(a_busy), .o_done(a_done)
    );

    lstm_seq_ctrl #(.N_X(5), .N_H(2), .N_UNIT(3), .N_T(3), .AW(16)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b),
`ifdef LSTM_SEQ_CTRL_STALL_EN
        .i_stall(stall),
`endif
        .o_acc_x(b_acc_x), .o_acc_h(b_acc_h), .o_x_en(b_x_en), .o_h_en(b_h_en),
        .o_x_addr(b_xa), .o_w_addr(b_wa), .o_h_addr(b_ha), .o_u_addr(b_ua),
        .o_h_bank(b_bank), .o_c_addr(b_ca), .o_first(b_first), .o_wr(b_wr),
        .o_busy(b_busy), .o_done(b_done)
    );

    assign obs[0] = {a_acc_x, a_acc_h, a_x_en, a_h_en, a_xa, a_wa, a_ha, a_ua,
                     a_bank, a_ca, a_first, a_wr, a_busy, a_done};
    assign obs[1] = {b_acc_x, b_acc_h, b_x_en, b_h_en, b_xa, b_wa, b_ha, b_ua,
                     b_bank, b_ca, b_first, b_wr, b_busy, b_done};

    function automatic int qsz(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic obs_t msk(input obs_t v, input logic [1:0] m);
        obs_t r;
        r = v;
        if (m >= 2'd1) begin
            r.xa = '0; r.wa = '0; r.ha = '0; r.ua = '0;
        end
        if (m == 2'd2) begin
            r.bank = 1'b0; r.ca = '0; r.first = 1'b0;
        end
        return r;
    endfunction

    // Expected schedule of one run: per unit a load term, N_IN-1 accumulate terms, a settle
    // cycle and a write cycle; units nested in timesteps; one done cycle at the end.
    task automatic build(input int d);
        int nx, nh, nu, nt, nin;
        exp_t e;
        if (d == 0) begin nx = 4; nh = 4; nu = 2; nt = 2; end
        else begin nx = 5; nh = 2; nu = 3; nt = 3; end
        nin = (nx > nh) ? nx : nh;
        for (int s = 0; s < nt; s++) begin
            for (int u = 0; u < nu; u++) begin
                for (int c = 0; c < nin + 2; c++) begin
                    e = '0;
                    e.o.busy  = 1'b1;
                    e.o.bank  = s[0];
                    e.o.ca    = 16'(u);
                    e.o.first = (s == 0);
                    if (c < nin) begin
                        e.stallable = 1'b1;
                        e.o.acc_x = (c != 0);
                        e.o.acc_h = (c != 0);
                        e.o.x_en  = (c < nx);
                        e.o.h_en  = (c < nh) && (s != 0);
                        e.o.xa    = 16'(s * nx + c);
                        e.o.wa    = 16'(u * nx + c);
                        e.o.ha    = 16'(c);
                        e.o.ua    = 16'(u * nh + c);
                    end else begin
                        e.stallable = (c == nin);
                        e.mask      = 2'd1;
                        e.o.acc_x   = 1'b1;
                        e.o.acc_h   = 1'b1;
                        e.o.wr      = (c == nin + 1);
                    end
                    if (d == 0) qa.push_back(e); else qb.push_back(e);
                end
            end
        end
        e = '0;
        e.mask   = 2'd2;
        e.o.busy = 1'b1;
        e.o.done = 1'b1;
        if (d == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        obs_t ex, ob;
        logic stl;
        if (sb_on && !rst) begin
            for (int d = 0; d < 2; d++) begin
                ob = obs[d];
                if (qsz(d) == 0) begin
                    n_cmp++;
                    if (ob.busy !== 1'b0 || ob.wr !== 1'b0 || ob.done !== 1'b0 ||
                        ob.x_en !== 1'b0 || ob.h_en !== 1'b0 || ob.acc_x !== 1'b0) begin
                        n_fail++;
                        $display("FAIL idle dut%0d: got %h need busy/wr/done/en/acc all 0", d, ob);
                    end
                end else begin
                    e   = (d == 0) ? qa[0] : qb[0];
                    ex  = e.o;
                    stl = stall && e.stallable;
                    if (stl) begin
                        ex.x_en = 1'b0;
                        ex.h_en = 1'b0;
                    end
                    ex = msk(ex, e.mask);
                    ob = msk(ob, e.mask);
                    n_cmp++;
                    if (ob !== ex) begin
                        n_fail++;
                        $display("FAIL sched dut%0d: got %h need %h (left %0d)", d, ob, ex, qsz(d));
                    end
                    if (!stl) begin
                        if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                    end
                end
            end
        end
    end

    task automatic launch(input int d);
        @(posedge clk); #1;
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        if (d == 0) start_a = 1'b0; else start_b = 1'b0;
        build(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (obs[d] !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h need 0", d, obs[d]);
            end
        end
        rst   = 1'b0;
        sb_on = 1'b1;
    endtask

    task automatic test_single_run();
        int wrc[$];
        int done_c, h0, h1, got;
        logic [5:0] accp;
        done_c = 0; h0 = 0; h1 = 0; accp = '0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        launch(0);
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            @(negedge clk);
            if (a_wr) wrc.push_back(c);
            if (a_done) done_c = c;
            if (c <= 6) accp = {accp[4:0], a_acc_x};
            if (a_h_en) begin
                if (c <= 12) h0++; else h1++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (wrc.size() != 4) begin
            n_fail++;
            $display("FAIL wr_count: got %0d need 4", wrc.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < wrc.size()) ? wrc[i] : -1;
            n_cmp++;
            if (got != 6 * (i + 1)) begin
                n_fail++;
                $display("FAIL wr_cycle[%0d]: got %0d need %0d", i, got, 6 * (i + 1));
            end
        end
        n_cmp++;
        if (done_c != 25) begin
            n_fail++;
            $display("FAIL done_cycle: got %0d need 25", done_c);
        end
        n_cmp++;
        if (accp !== 6'b011111) begin
            n_fail++;
            $display("FAIL acc_pattern: got %b need 011111", accp);
        end
        n_cmp++;
        if (h0 != 0 || h1 != 8) begin
            n_fail++;
            $display("FAIL h_en_count: got step0=%0d step1=%0d need 0 and 8", h0, h1);
        end
    endtask

    task automatic test_unequal();
        int wa_seq[$];
        int done_c, xcnt, hcnt, h0, got;
        logic bank0, bank1, first0, first1;
        done_c = 0; xcnt = 0; hcnt = 0; h0 = 0;
        bank0 = 1'b1; bank1 = 1'b0; first0 = 1'b0; first1 = 1'b1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        launch(1);
        for (int c = 1; c <= 90 && done_c == 0; c++) begin
            @(negedge clk);
            if (b_done) done_c = c;
            if (c <= 21 && b_h_en) h0++;
            if (c >= 22 && c <= 28) begin
                if (b_x_en) xcnt++;
                if (b_h_en) hcnt++;
            end
            if (c >= 29 && c <= 35 && b_x_en) wa_seq.push_back(int'(b_wa));
            if (c == 1) begin bank0 = b_bank; first0 = b_first; end
            if (c == 22) begin bank1 = b_bank; first1 = b_first; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done_c != 64) begin
            n_fail++;
            $display("FAIL unequal_done: got %0d need 64", done_c);
        end
        n_cmp++;
        if (xcnt != 5 || hcnt != 2 || h0 != 0) begin
            n_fail++;
            $display("FAIL unequal_en: got x=%0d h=%0d h_step0=%0d need 5 2 0", xcnt, hcnt, h0);
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < wa_seq.size()) ? wa_seq[i] : -1;
            n_cmp++;
            if (got != 5 + i) begin
                n_fail++;
                $display("FAIL w_addr_unit1[%0d]: got %0d need %0d", i, got, 5 + i);
            end
        end
        n_cmp++;
        if (bank0 !== 1'b0 || bank1 !== 1'b1 || first0 !== 1'b1 || first1 !== 1'b0) begin
            n_fail++;
            $display("FAIL bank_first: got bank %b/%b first %b/%b need 0/1 1/0",
                     bank0, bank1, first0, first1);
        end
    endtask

    task automatic abort_and_check(input int d, input int quiet);
        int wrs, dns;
        wrs = 0; dns = 0;
        #1;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        n_cmp++;
        if (obs[d] !== '0) begin
            n_fail++;
            $display("FAIL abort_zero dut%0d: got %h need 0", d, obs[d]);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < quiet; c++) begin
            @(negedge clk);
            if (obs[d].wr) wrs++;
            if (obs[d].done) dns++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (wrs != 0 || dns != 0) begin
            n_fail++;
            $display("FAIL abort_quiet dut%0d: got wr=%0d done=%0d need 0 0", d, wrs, dns);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_c, r;
        obs_t o1;
        launch(0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c < 9) begin @(posedge clk); #1; end
        end
        abort_and_check(0, 20);
        done_c = 0;
        launch(0);
        o1 = '0;
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            @(negedge clk);
            if (c == 1) o1 = obs[0];
            if (a_done) done_c = c;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (o1.ca !== 16'd0 || o1.first !== 1'b1 || o1.xa !== 16'd0 || done_c != 25) begin
            n_fail++;
            $display("FAIL restart: got c_addr=%0d first=%b x_addr=%0d done@%0d need 0 1 0 25",
                     o1.ca, o1.first, o1.xa, done_c);
        end
        r = $urandom_range(2, 60);
        launch(1);
        for (int c = 1; c <= r; c++) begin
            @(negedge clk);
            if (c < r) begin @(posedge clk); #1; end
        end
        abort_and_check(1, 70);
    endtask

    task automatic test_back_to_back();
        int dns, done1, done2;
        dns = 0; done1 = 0; done2 = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        build(0);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (a_done) begin dns++; done1 = c; end
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        build(0);
        for (int c = 1; c <= 40 && done2 == 0; c++) begin
            @(negedge clk);
            if (a_done) done2 = c;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dns != 1 || done1 != 25) begin
            n_fail++;
            $display("FAIL held_start: got %0d dones last@%0d need 1 @25", dns, done1);
        end
        n_cmp++;
        if (done2 != 25) begin
            n_fail++;
            $display("FAIL second_run: got done@%0d need 25", done2);
        end
    endtask

`ifdef LSTM_SEQ_CTRL_STALL_EN
    task automatic test_stall();
        int done_c, xbad;
        done_c = 0; xbad = 0;
        launch(0);
        for (int c = 1; c <= 60 && done_c == 0; c++) begin
            stall = (c >= 3 && c <= 5);
            @(negedge clk);
            if (stall && a_x_en) xbad++;
            if (a_done) done_c = c;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        n_cmp++;
        if (done_c != 28 || xbad != 0) begin
            n_fail++;
            $display("FAIL stall: got done@%0d x_en_in_stall=%0d need 28 0", done_c, xbad);
        end
    endtask

    task automatic test_random_stall();
        int done_c;
        done_c = 0;
        launch(1);
        for (int c = 1; c <= 400 && done_c == 0; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (b_done) done_c = c;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        n_cmp++;
        if (done_c < 64) begin
            n_fail++;
            $display("FAIL random_stall_done: got done@%0d need >=64", done_c);
        end
    endtask
`endif

    initial begin
        n_cmp = 0; n_fail = 0;
        sb_on = 1'b0; start_a = 1'b0; start_b = 1'b0; stall = 1'b0;
        test_reset();
        test_single_run();
        test_unequal();
        test_reset_mid_run();
        test_back_to_back();
`ifdef LSTM_SEQ_CTRL_STALL_EN
        test_stall();
        test_random_stall();
`endif
        repeat (3) @(posedge clk);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_schedule: got %0d/%0d need 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencer for one LSTM core. It drives the core's `acc_x`/`acc_h` MAC controls, generates the operand addresses for input, hidden, weight and state memories, and issues write strobes that capture the core's `c`/`h` results. It sweeps `N_UNIT` hidden units per timestep over `N_T` timesteps, then pulses done. It sits between the top-level start/done handshake and the `lstm_core` datapath plus its memories.

## Interface
- `N_X`, 4: input vector length (x MAC terms per unit).
- `N_H`, 4: hidden vector length (h MAC terms per unit).
- `N_UNIT`, 4: hidden units computed per timestep.
- `N_T`, 8: timesteps per run.
- `AW`, 16: width of every address output.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_start` in 1: run request, sampled only in IDLE.
- `o_acc_x`, `o_acc_h` out 1: to core `acc_x`/`acc_h`. 0 = MAC loads product; 1 = MAC accumulates.
- `o_x_en`, `o_h_en` out 1: operand enables. When 0, the top forces the x/h operand to zero.
- `o_x_addr` out AW: `step*N_X + k`.
- `o_w_addr` out AW: `unit*N_X + k`.
- `o_h_addr` out AW: `k`. Read from h bank `o_h_bank`.
- `o_u_addr` out AW: `unit*N_H + k`.
- `o_h_bank` out 1: read bank, equal to `step[0]`. Writes go to the other bank.
- `o_c_addr` out AW: `unit`. Previous-state read address, and also the write address.
- `o_first` out 1: `step==0`. The top forces `i_prev_state` to 0 while this is high.
- `o_wr` out 1: one-cycle strobe that writes core `o_c` and `o_h` at `o_c_addr`.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse at end of run.

## Operation
- Definitions:
  - `N_IN = max(N_X, N_H)`.
  - Counters: `k` (0..N_IN-1), `unit` (0..N_UNIT-1), `step` (0..N_T-1).
- States and transitions:
  - IDLE: go to LOAD if `i_start`. Clear `k`, `unit`, `step`.
  - LOAD: `k=0`, acc outputs 0. Go to ACC if `N_IN>1`, else to WAIT.
  - ACC: acc outputs 1, `k` increments. When `k==N_IN-1`, go to WAIT.
  - WAIT: one cycle for the MAC register to settle. Acc outputs 1, both enables 0, so the MACs hold their value.
  - WRITE: `o_wr=1`, addresses still reflect `unit`.
    - If `unit<N_UNIT-1`: `unit++`, go to LOAD.
    - Else if `step<N_T-1`: `unit=0`, `step++`, go to LOAD.
    - Else go to DONE.
  - DONE: `o_done=1`, go to IDLE.
- Operand enables:
  - `o_x_en = (LOAD|ACC) && k<N_X`.
  - `o_h_en = (LOAD|ACC) && k<N_H && !o_first`.
  - The shorter stream is padded with zero operands, so its MAC adds 0.
- Addresses are combinational from the counters. Memories are asynchronous-read, so operands are valid in the same cycle as the acc signals.
- All address arithmetic is unsigned and truncated to AW bits. Elaboration fails if `N_UNIT*N_X`, `N_UNIT*N_H` or `N_T*N_X` exceeds `2**AW`.

## Timing
- Reset value of every output is 0 and the state is IDLE.
- Reset asserted mid-run aborts immediately: no `o_wr` and no `o_done` is issued.
- Cycles per unit: `N_IN + 2`.
- `o_done` is asserted `N_T*N_UNIT*(N_IN+2) + 1` cycles after the `i_start` sample edge.
- `i_start` is ignored outside IDLE, including in the DONE cycle. A new run can start in the cycle after DONE.
- `o_wr` for a unit is asserted exactly once per unit per step. Successive strobes are `N_IN+2` cycles apart.
- Bank alternation: the bank written during step s is read as `o_h_bank` during step s+1.

## Configuration
- Macro `LSTM_SEQ_CTRL_STALL_EN`.
- When defined:
  - Adds input `i_stall` (1 bit).
  - While `i_stall=1` in LOAD/ACC/WAIT, all counters and the state freeze and `o_x_en=o_h_en=0`. In ACC the acc outputs stay 1, so the MACs add zero. LOAD repeats, reloading a zero product.
  - Stall in WRITE is deferred: WRITE completes, then the stall applies from LOAD.
  - Stall has no effect in IDLE or DONE.
- When undefined: there is no port and no stall logic, and timing is exactly as above.

## Structure
- Package `lstm_pkg` holds:
  - the state encoding constants (IDLE=0, LOAD=1, ACC=2, WAIT=3, WRITE=4, DONE=5);
  - a `clog2` function;
  - default AW.
- One sub-module, `mod_counter`: a parameterised wrap-around counter with `en`, `clr` and `last` outputs. It is instantiated for `k`, `unit` and `step`.

## Test plan
- **Single run:** N_X=4, N_H=4, N_UNIT=2, N_T=2; pulse `i_start`. Required response:
  - `o_wr` at cycles 6, 12, 18, 24;
  - `o_done` at cycle 25;
  - `o_acc_x` pattern per unit is 0,1,1,1,1,1.
- **Unequal lengths:** N_X=5, N_H=2. Per unit, `o_x_en` is high for 5 cycles and `o_h_en` for 2 (step≥1), with 0 for the rest. `o_w_addr` for unit 1 runs 5..9.
- **First step and banks:** with `o_first=1`, `o_h_en` stays 0 throughout step 0. `o_h_bank` is 0 in step 0 and 1 in step 1.
- **Reset mid-run:** assert `rst` during ACC of unit 1. All outputs go to 0 at once. A subsequent `i_start` restarts at unit 0, step 0.
- **Start ignored while busy:** `i_start` held high for the whole run gives exactly one `o_done`. A second run starts the cycle after DONE.
- **Stall (macro defined):** 3-cycle `i_stall` in ACC at k=2. `o_done` moves exactly 3 cycles later, and `o_x_en=0` during the stall.
